// File: rtl/sequence_transmitter_fsm.sv
// Bit-serial pattern transmitter: sends a latched PATTERN_W-bit pattern MSB first for N frames, GAP zero cycles apart.
// First bit appears the cycle after an accepted start; no backpressure, start is ignored while busy, abort returns to idle.
module sequence_transmitter_fsm #(
    parameter int PATTERN_W = 6,
    parameter int GAP       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [7:0]           frames,
    input  logic                 abort,
    output logic                 a,
    output logic                 a_valid,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           frames_left
);

    localparam int BW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(PATTERN_W - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [PATTERN_W-1:0] shreg, shreg_nxt;
    logic [PATTERN_W-1:0] pat, pat_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]        gap_cnt, gap_cnt_nxt;
    logic [7:0]           frame_cnt, frame_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            pat       <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            pat       <= pat_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        pat_nxt       = pat;
        bit_cnt_nxt   = bit_cnt;
        gap_cnt_nxt   = gap_cnt;
        frame_cnt_nxt = frame_cnt;
        case (state)
            ST_IDLE: begin
                if (start && (frames != 8'd0)) begin
                    shreg_nxt     = pattern_in;
                    pat_nxt       = pattern_in;
                    frame_cnt_nxt = frames;
                    bit_cnt_nxt   = BIT_LAST;
                    state_nxt     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nxt     = ST_IDLE;
                    shreg_nxt     = '0;
                    bit_cnt_nxt   = '0;
                    frame_cnt_nxt = '0;
                end else begin
                    shreg_nxt   = {shreg[PATTERN_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        frame_cnt_nxt = frame_cnt - 8'd1;
                        if (frame_cnt == 8'd1) begin
                            state_nxt = ST_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt_nxt = GAP_LOAD;
                            state_nxt   = ST_GAP;
                        end else begin
                            // back-to-back: next frame's MSB follows with no dead cycle
                            shreg_nxt   = pat;
                            bit_cnt_nxt = BIT_LAST;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nxt     = ST_IDLE;
                    shreg_nxt     = '0;
                    gap_cnt_nxt   = '0;
                    frame_cnt_nxt = '0;
                end else if (gap_cnt == '0) begin
                    shreg_nxt   = pat;
                    bit_cnt_nxt = BIT_LAST;
                    state_nxt   = ST_SEND;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign a           = (state == ST_SEND) & shreg[PATTERN_W-1];
    assign a_valid     = (state == ST_SEND);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign frames_left = frame_cnt;

endmodule

// File: tb/tb_sequence_transmitter_fsm.sv
// Directed bench for sequence_transmitter_fsm: one instance with GAP=0, one with GAP=2.
module tb_sequence_transmitter_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic [5:0] pat0 = '0;
    logic [7:0] frames0 = '0;
    logic       a0, v0, b0, d0;
    logic [7:0] fl0;
    logic       start2 = 1'b0, abort2 = 1'b0;
    logic [5:0] pat2 = '0;
    logic [7:0] frames2 = '0;
    logic       a2, v2, b2, d2;
    logic [7:0] fl2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [5:0] hist = '0;
    logic [5:0] det_pat = '0;
    int det_cnt = 0;

    always #5 clk = ~clk;

    sequence_transmitter_fsm #(.PATTERN_W(6), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pattern_in(pat0), .frames(frames0),
        .abort(abort0), .a(a0), .a_valid(v0), .busy(b0), .done(d0), .frames_left(fl0)
    );

    sequence_transmitter_fsm #(.PATTERN_W(6), .GAP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pattern_in(pat2), .frames(frames2),
        .abort(abort2), .a(a2), .a_valid(v2), .busy(b2), .done(d2), .frames_left(fl2)
    );

    function automatic logic [11:0] out0();
        return {a0, v0, b0, d0, fl0};
    endfunction

    function automatic logic [11:0] out2();
        return {a2, v2, b2, d2, fl2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then sample 1 time unit later; feeds the detector model from u0
    task automatic tick();
        @(posedge clk);
        #1;
        hist = {hist[4:0], a0};
        if (hist == det_pat) det_cnt++;
    endtask

    // checks n frames of pat on u0 starting at the first SEND cycle, then DONE and IDLE
    task automatic run0(input logic [5:0] pat, input int n, input bit disturb);
        start0 = 1'b0;
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < 6; k++) begin
                chk("send0", 32'(out0()), 32'({pat[5-k], 1'b1, 1'b1, 1'b0, 8'(n - f)}));
                if (disturb && f == 0 && k == 2) begin
                    start0  = 1'b1;
                    pat0    = ~pat;
                    frames0 = 8'd7;
                end else begin
                    start0 = 1'b0;
                end
                tick();
            end
        end
        chk("done0", 32'(out0()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 8'd0}));
        tick();
        chk("idle0", 32'(out0()), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("reset0", 32'(out0()), 32'd0);
        chk("reset2", 32'(out2()), 32'd0);
        rst_n = 1'b1;
        tick();

        // single frame
        det_pat = 6'b110011;
        hist    = '0;
        det_cnt = 0;
        start0 = 1'b1; pat0 = 6'b110011; frames0 = 8'd1;
        tick();
        run0(6'b110011, 1, 1'b0);
        chk("det_single", 32'(det_cnt), 32'd1);

        // frames=0 request is ignored
        start0 = 1'b1; frames0 = 8'd0;
        tick();
        start0 = 1'b0;
        chk("zero_frames_a", 32'(out0()), 32'd0);
        tick();
        chk("zero_frames_b", 32'(out0()), 32'd0);

        // three back-to-back frames with a disturbing start mid-frame
        det_cnt = 0;
        start0 = 1'b1; pat0 = 6'b110011; frames0 = 8'd3;
        tick();
        run0(6'b110011, 3, 1'b1);
        chk("det_triple", 32'(det_cnt), 32'd3);

        // GAP=2 instance: 101010,0,0,101010
        start2 = 1'b1; pat2 = 6'b101010; frames2 = 8'd2;
        tick();
        start2 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 6; k++) begin
                chk("send2", 32'(out2()), 32'({k[0] ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, 8'(2 - f)}));
                tick();
            end
            if (f == 0) begin
                for (int g = 0; g < 2; g++) begin
                    chk("gap2", 32'(out2()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'd1}));
                    tick();
                end
            end
        end
        chk("done2", 32'(out2()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 8'd0}));
        tick();
        chk("idle2", 32'(out2()), 32'd0);

        // abort in the 3rd bit of frame 2
        start0 = 1'b1; pat0 = 6'b110011; frames0 = 8'd4;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("abort_f2b0", 32'(out0()), 32'({1'b1, 1'b1, 1'b1, 1'b0, 8'd3}));
        tick();
        tick();
        chk("abort_f2b2", 32'(out0()), 32'({1'b0, 1'b1, 1'b1, 1'b0, 8'd3}));
        abort0 = 1'b1;
        tick();
        chk("abort_idle", 32'(out0()), 32'd0);
        tick();
        chk("abort_nodone", 32'(out0()), 32'd0);
        // start and abort together in IDLE: start wins
        start0 = 1'b1; pat0 = 6'b101101; frames0 = 8'd1;
        tick();
        abort0 = 1'b0;
        run0(6'b101101, 1, 1'b0);

        // asynchronous reset in the middle of a gap
        start2 = 1'b1; pat2 = 6'b111000; frames2 = 8'd3;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("gap_pre_rst", 32'(out2()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'd2}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(out2()), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst", 32'(out2()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_transmitter_fsm.md
Name: sequence_transmitter_fsm

Overview:
- Bit-serial pattern transmitter. On a start request it emits a PATTERN_W-bit pattern MSB first on a single-bit line, repeated a programmable number of frames.
- Optional idle-zero gaps separate frames.
- Acts as the stimulus/transmit end for the team's serial sequence detectors: its output `a` connects directly to a detector's `a` input on the same clock.

Parameters:
- PATTERN_W, 6, pattern length in bits (>= 2)
- GAP, 0, number of forced-0 cycles between consecutive frames (0 = back-to-back)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin transmission, sampled in IDLE only
- pattern_in  input  PATTERN_W  pattern to send, latched on an accepted start
- frames  input  8  number of frames to send, latched on an accepted start; 0 means the request is ignored
- abort  input  1  terminate an in-progress transmission
- a  output  1  serial data bit
- a_valid  output  1  high while `a` carries a pattern bit (state SEND)
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle pulse after the last bit of the last frame
- frames_left  output  8  frames not yet completed, including the one in flight

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register, bit counter, gap counter and frame counter = 0.
  - a = 0, a_valid = 0, busy = 0, done = 0, frames_left = 0.
- Outputs are Moore-style: decoded only from registered state and datapath registers, with no combinational path from any input.
  - a = shreg[PATTERN_W-1] in SEND, otherwise 0.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 and frames!=0: latch shreg=pattern_in, frame_cnt=frames, bit_cnt=PATTERN_W-1; go to SEND.
  - start=1 and frames==0: ignored, stay in IDLE, no done pulse.
- SEND:
  - Each cycle, shift shreg left by 1 (shifting in 0) and decrement bit_cnt.
  - When bit_cnt==0 (last bit of the frame is on `a`), frame_cnt decrements at that clock edge.
  - If the decremented frame_cnt is 0, go to DONE.
  - Otherwise, if GAP>0, load gap_cnt=GAP-1 and go to GAP.
  - Otherwise (GAP=0), reload shreg from the latched pattern copy, set bit_cnt=PATTERN_W-1 and stay in SEND. Frames are then contiguous with no dead cycle.
- GAP:
  - a=0, a_valid=0.
  - When gap_cnt==0: reload shreg, set bit_cnt=PATTERN_W-1, go to SEND. Otherwise decrement gap_cnt.
- DONE:
  - done=1 for exactly one cycle, a=0.
  - Always go to IDLE next; start in the DONE cycle is ignored.
- Pattern storage: a pattern copy register holds the latched value for reloads. pattern_in and frames changing after acceptance have no effect.
- Latency:
  - start accepted at edge t puts bit PATTERN_W-1 on `a` during cycle t..t+1.
  - One frame occupies exactly PATTERN_W cycles of a_valid.
  - Total busy cycles = frames*PATTERN_W + (frames-1)*GAP + 1 (the DONE cycle).
- abort:
  - Sampled in SEND, GAP or DONE; go to IDLE at the next edge.
  - No done pulse; frames_left = 0; a = 0 from that cycle on.
  - abort in IDLE has no effect.
  - abort and start asserted together in IDLE: start wins.
- start while busy: ignored (no queuing, no restart).
- frames_left = frame_cnt.
  - Decrements at the edge that ends each frame's last bit.
  - Reads 0 in DONE and IDLE.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously), with no done pulse. Transmission does not resume after reset release.
- Counter widths:
  - bit_cnt is $clog2(PATTERN_W) bits.
  - gap_cnt is max(1, $clog2(GAP)) bits.
  - frame_cnt is 8 bits; 255 frames is the maximum.

Test Plan:
- Single frame: reset, then start with pattern_in=6'b110011, frames=1, GAP=0 -> a = 1,1,0,0,1,1 on 6 consecutive cycles, a_valid high for those 6 only; done pulses on cycle 7; busy high for 7 cycles; a detector model on `a` flags exactly once.
- Back-to-back repeats: frames=3, GAP=0 -> 18 contiguous valid bits 110011110011110011; frames_left steps 3,2,1,0; detector flags 3 times; one done pulse at cycle 19.
- Gap insertion: GAP=2, frames=2, pattern 6'b101010 -> sequence 101010,0,0,101010 with a_valid low in the 2 gap cycles; done at cycle 15.
- Ignored requests: start with frames=0 -> busy stays 0, no done. A second start mid-frame with a different pattern_in -> output stream unchanged.
- Abort: frames=4, assert abort in the 3rd bit of frame 2 -> next cycle IDLE, a=0, frames_left=0, no done pulse. A new start is then accepted normally.
- Async reset: drop rst_n between clock edges mid-GAP -> a, a_valid, busy, done, frames_left all go to 0 before the next edge. After release, the block idles until a new start.
